gpio_serial_cfg_ctrl: RTL and testbench

//  Sequencer that loads per-pad configuration words into the two user-GPIO serial config chains of the mprj_io padframe.

---
 rtl/gpio_serial_cfg_ctrl_pkg.sv | 29 ++
 rtl/gpio_serial_cfg_ctrl_if.sv | 40 ++++
 rtl/gpio_serial_cfg_ctrl_serial_clk_tick.sv | 37 +++
 rtl/gpio_serial_cfg_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_gpio_serial_cfg_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_serial_cfg_ctrl_pkg.sv
// Shared types and constants for the GPIO serial configuration loader.
//   state_e      : sequencer states
//   Def*         : default geometry (pads, bits per pad, serial clock divider)
//   GpioMode*    : common 13-bit pad mode words, also used by the bench
package gpio_serial_cfg_ctrl_pkg;

  localparam int unsigned DefNumIo   = 38;
  localparam int unsigned DefCfgBits = 13;
  localparam int unsigned DefClkDiv  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFetchA,
    StFetchB,
    StFetchC,
    StShift,
    StLoad,
    StFin
  } state_e;

  localparam logic [DefCfgBits-1:0] GpioModeMgmtStdInputNopull = 13'h0403;
  localparam logic [DefCfgBits-1:0] GpioModeMgmtStdOutput      = 13'h1809;
  localparam logic [DefCfgBits-1:0] GpioModeMgmtStdBidir       = 13'h1801;
  localparam logic [DefCfgBits-1:0] GpioModeUserStdInputNopull = 13'h0402;
  localparam logic [DefCfgBits-1:0] GpioModeUserStdOutput      = 13'h1808;
  localparam logic [DefCfgBits-1:0] GpioModeUserStdBidir       = 13'h1800;

endpackage

// File: rtl/gpio_serial_cfg_ctrl_if.sv
// Bundle of control, config-store and serial-chain signals of the loader.
//   start/abort      : host requests           busy/done        : host status
//   cfg_rd/cfg_addr  : config store read       cfg_rdata        : store data (1 cycle latency)
//   serial_*         : the two padframe configuration chains
// master: the loader itself; slave: host, config store and padframe side.
interface gpio_serial_cfg_ctrl_if
  import gpio_serial_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IO   = DefNumIo,
  parameter int unsigned CFG_BITS = DefCfgBits
) ();

  localparam int unsigned AddrW = $clog2(NUM_IO);

  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                cfg_rd;
  logic [AddrW-1:0]    cfg_addr;
  logic [CFG_BITS-1:0] cfg_rdata;
  logic                serial_clock;
  logic                serial_resetn;
  logic                serial_load;
  logic                serial_data_1;
  logic                serial_data_2;

  modport master (
    input  start, abort, cfg_rdata,
    output busy, done, cfg_rd, cfg_addr,
    output serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2
  );

  modport slave (
    output start, abort, cfg_rdata,
    input  busy, done, cfg_rd, cfg_addr,
    input  serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2
  );

endinterface

// File: rtl/gpio_serial_cfg_ctrl_serial_clk_tick.sv
// Half-period timer for the serial chain clock.
//   i_clock   : system clock
//   i_resetb  : asynchronous active-low reset
//   i_restart : forces the count back to zero for the next cycle
//   o_tick    : high in the last system cycle of each CLK_DIV-cycle phase
module gpio_serial_cfg_ctrl_serial_clk_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clock,
  input  logic i_resetb,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned     CntW    = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    o_tick  = (r_cnt == CntLast);
    w_cnt_d = r_cnt + CntW'(1);
    if (i_restart || o_tick) begin
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_cfg_ctrl.sv
// Loads one CFG_BITS word per pad into the two user-GPIO serial config chains, then
// pulses serial_load so every pad control block latches at once.
//   i_clock  : system clock, all logic on the rising edge
//   i_resetb : asynchronous active-low reset
//   io_bus   : start/abort/busy/done, config store read port, serial chain outputs
// Chain 1 carries pads 0..H-1 and chain 2 pads H..NUM_IO-1; both are shifted together,
// farthest pad first, each word MSB first.
module gpio_serial_cfg_ctrl
  import gpio_serial_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IO   = DefNumIo,
  parameter int unsigned CFG_BITS = DefCfgBits,
  parameter int unsigned CLK_DIV  = DefClkDiv
) (
  input logic                   i_clock,
  input logic                   i_resetb,
  gpio_serial_cfg_ctrl_if.master io_bus
);

  localparam int unsigned H     = NUM_IO / 2;
  localparam int unsigned AddrW = $clog2(NUM_IO);
  localparam int unsigned BitW  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned StepW = (H > 1) ? $clog2(H) : 1;

  localparam logic [BitW-1:0]  BitLast    = BitW'(CFG_BITS - 1);
  localparam logic [StepW-1:0] StepLast   = StepW'(H - 1);
  localparam logic [AddrW-1:0] AddrHalf   = AddrW'(H);
  localparam logic [AddrW-1:0] AddrHalfM1 = AddrW'(H - 1);

  state_e              r_state, w_state_d;
  logic [StepW-1:0]    r_step, w_step_d;
  logic [BitW-1:0]     r_bit, w_bit_d;
  logic                r_sclk, w_sclk_d;
  logic [CFG_BITS-1:0] r_sh1, w_sh1_d;
  logic [CFG_BITS-1:0] r_sh2, w_sh2_d;
  logic                w_tick;
  logic                w_restart;

  // Every state starts with a fresh CLK_DIV phase; idle keeps the timer parked.
  assign w_restart = (w_state_d != r_state) || (r_state == StIdle);

  gpio_serial_cfg_ctrl_serial_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clock   (i_clock),
    .i_resetb  (i_resetb),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    w_bit_d   = r_bit;
    w_sclk_d  = r_sclk;
    w_sh1_d   = r_sh1;
    w_sh2_d   = r_sh2;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start && !io_bus.abort) begin
          w_state_d = StClr;
          w_step_d  = '0;
          w_bit_d   = '0;
          w_sclk_d  = 1'b0;
        end
      end
      StClr: begin
        if (w_tick) begin
          w_state_d = StFetchA;
        end
      end
      StFetchA: begin
        w_state_d = StFetchB;
      end
      StFetchB: begin
        // Data for the chain 1 read issued in FETCH_A.
        w_sh1_d   = io_bus.cfg_rdata;
        w_state_d = StFetchC;
      end
      StFetchC: begin
        w_sh2_d   = io_bus.cfg_rdata;
        w_state_d = StShift;
      end
      StShift: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_d = 1'b1;
          end else begin
            // Falling edge: data was held through the whole high phase, advance now.
            w_sclk_d = 1'b0;
            w_sh1_d  = r_sh1 << 1;
            w_sh2_d  = r_sh2 << 1;
            if (r_bit == BitLast) begin
              w_bit_d = '0;
              if (r_step == StepLast) begin
                w_state_d = StLoad;
              end else begin
                w_step_d  = r_step + StepW'(1);
                w_state_d = StFetchA;
              end
            end else begin
              w_bit_d = r_bit + BitW'(1);
            end
          end
        end
      end
      StLoad: begin
        if (w_tick) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Abort drops everything back to reset values; the chains are never loaded.
    if (io_bus.abort && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_step_d  = '0;
      w_bit_d   = '0;
      w_sclk_d  = 1'b0;
      w_sh1_d   = '0;
      w_sh2_d   = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state <= StIdle;
      r_step  <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_sh1   <= '0;
      r_sh2   <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      r_bit   <= w_bit_d;
      r_sclk  <= w_sclk_d;
      r_sh1   <= w_sh1_d;
      r_sh2   <= w_sh2_d;
    end
  end

  always_comb begin
    io_bus.busy          = 1'b1;
    io_bus.done          = 1'b0;
    io_bus.cfg_rd        = 1'b0;
    io_bus.cfg_addr      = '0;
    io_bus.serial_resetn = 1'b1;
    io_bus.serial_load   = 1'b0;
    unique case (r_state)
      StIdle: begin
        io_bus.busy = 1'b0;
      end
      StClr: begin
        io_bus.serial_resetn = 1'b0;
      end
      StFetchA: begin
        io_bus.cfg_rd   = 1'b1;
        io_bus.cfg_addr = AddrHalfM1 - AddrW'(r_step);
      end
      StFetchB: begin
        io_bus.cfg_rd   = 1'b1;
        io_bus.cfg_addr = AddrHalf + AddrW'(r_step);
      end
      StLoad: begin
        io_bus.serial_load = 1'b1;
      end
      StFin: begin
        io_bus.busy = 1'b0;
        io_bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Chain clock and data come straight from flops so the padframe sees clean edges.
  assign io_bus.serial_clock  = r_sclk;
  assign io_bus.serial_data_1 = r_sh1[CFG_BITS-1];
  assign io_bus.serial_data_2 = r_sh2[CFG_BITS-1];

endmodule

// File: tb/tb_gpio_serial_cfg_ctrl.sv
`timescale 1ns/1ps
module tb_gpio_serial_cfg_ctrl;
  import gpio_serial_cfg_ctrl_pkg::*;

  localparam int unsigned NumIo  = 38;
  localparam int unsigned Cb     = 13;
  localparam int unsigned ClkDiv = 2;
  localparam int unsigned H      = NumIo / 2;
  localparam int unsigned SNumIo = 4;
  localparam int unsigned SH     = SNumIo / 2;

  // {busy, done, cfg_rd, serial_clock, serial_resetn, serial_load, data_1, data_2, cfg_addr}
  localparam logic [13:0] MRst = {8'b0000_1000, 6'd0};
  localparam logic [9:0]  SRst = {8'b0000_1000, 2'd0};

  logic clk;
  logic resetb;
  int   n_tests;
  int   n_fail;

  gpio_serial_cfg_ctrl_if #(.NUM_IO(NumIo), .CFG_BITS(Cb)) m_if ();
  gpio_serial_cfg_ctrl_if #(.NUM_IO(SNumIo), .CFG_BITS(Cb)) s_if ();

  gpio_serial_cfg_ctrl #(.NUM_IO(NumIo), .CFG_BITS(Cb), .CLK_DIV(ClkDiv)) u_dut (
    .i_clock  (clk),
    .i_resetb (resetb),
    .io_bus   (m_if)
  );

  gpio_serial_cfg_ctrl #(.NUM_IO(SNumIo), .CFG_BITS(Cb), .CLK_DIV(1)) u_dut_small (
    .i_clock  (clk),
    .i_resetb (resetb),
    .io_bus   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] m_outs;
  logic [9:0]  s_outs;
  assign m_outs = {m_if.busy, m_if.done, m_if.cfg_rd, m_if.serial_clock, m_if.serial_resetn,
                   m_if.serial_load, m_if.serial_data_1, m_if.serial_data_2, m_if.cfg_addr};
  assign s_outs = {s_if.busy, s_if.done, s_if.cfg_rd, s_if.serial_clock, s_if.serial_resetn,
                   s_if.serial_load, s_if.serial_data_1, s_if.serial_data_2, s_if.cfg_addr};

  // Config stores: data one cycle after the read strobe, junk otherwise.
  logic [Cb-1:0] store [NumIo];
  logic [Cb-1:0] s_store [SNumIo];
  always @(posedge clk) begin
    m_if.cfg_rdata <= m_if.cfg_rd ? store[m_if.cfg_addr] : Cb'($urandom);
    s_if.cfg_rdata <= s_if.cfg_rd ? s_store[s_if.cfg_addr] : Cb'($urandom);
  end

  // Padframe model for the main DUT: two H-word shift chains plus per-pad latches.
  logic [H*Cb-1:0] sr1 = '0;
  logic [H*Cb-1:0] sr2 = '0;
  logic [Cb-1:0]   latched [NumIo];
  logic            prev_sclk = 1'b0;
  int              busy_cyc = 0;
  int              edges = 0;
  int              done_cnt = 0;
  int              load_cyc = 0;
  int              viol = 0;
  int              rd_log[$];

  always @(negedge clk) begin
    prev_sclk <= m_if.serial_clock;
    if (m_if.busy) busy_cyc <= busy_cyc + 1;
    if (m_if.done) done_cnt <= done_cnt + 1;
    if (m_if.serial_load) load_cyc <= load_cyc + 1;
    if (m_if.cfg_rd) rd_log.push_back(int'(m_if.cfg_addr));
    if ((m_if.serial_clock && (m_if.cfg_rd || m_if.serial_load || !m_if.serial_resetn)) ||
        (m_if.done && m_if.busy) || (m_if.cfg_rd && !m_if.busy))
      viol <= viol + 1;
    if (!m_if.serial_resetn) begin
      sr1 <= '0;
      sr2 <= '0;
    end else if (m_if.serial_clock && !prev_sclk) begin
      sr1   <= {sr1[H*Cb-2:0], m_if.serial_data_1};
      sr2   <= {sr2[H*Cb-2:0], m_if.serial_data_2};
      edges <= edges + 1;
    end
    if (m_if.serial_load) begin
      for (int p = 0; p < int'(H); p++) begin
        latched[p]   <= sr1[p*Cb +: Cb];
        latched[H+p] <= sr2[(int'(H)-1-p)*Cb +: Cb];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(NumIo); i++) store[i] = Cb'($urandom);
  endtask

  task automatic fill_modes();
    logic [Cb-1:0] modes [4];
    modes[0] = GpioModeMgmtStdOutput;
    modes[1] = GpioModeUserStdBidir;
    modes[2] = GpioModeUserStdOutput;
    modes[3] = GpioModeMgmtStdInputNopull;
    for (int i = 0; i < int'(NumIo); i++) store[i] = modes[$urandom_range(0, 3)];
  endtask

  // One complete load on the main DUT, checked against the spec-level expectations.
  task automatic full_run(input string tag, input bit poke_start);
    int b0, e0, d0, l0, i0, bad_k;
    bit got;
    b0 = busy_cyc; e0 = edges; d0 = done_cnt; l0 = load_cyc; i0 = rd_log.size();
    got = 1'b0;
    m_if.start = 1'b1;
    step();
    for (int c = 0; c < 3000; c++) begin
      m_if.start = poke_start && (c == 100 || c == 400 || c == 900);
      step();
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    m_if.start = 1'b0;
    repeat (5) step();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within 3000 cycles", tag);
    end
    n_tests++;
    if (busy_cyc - b0 !== 1049) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected 1049", tag, busy_cyc - b0);
    end
    n_tests++;
    if (edges - e0 !== int'(H * Cb)) begin
      n_fail++;
      $display("FAIL %s rising_edges: got %0d expected %0d", tag, edges - e0, H * Cb);
    end
    n_tests++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - d0);
    end
    n_tests++;
    if (load_cyc - l0 !== int'(ClkDiv)) begin
      n_fail++;
      $display("FAIL %s load_cycles: got %0d expected %0d", tag, load_cyc - l0, ClkDiv);
    end
    n_tests++;
    if (rd_log.size() - i0 !== int'(NumIo)) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d expected %0d", tag, rd_log.size() - i0, NumIo);
    end else begin
      n_tests++;
      if (rd_log[i0] !== int'(H) - 1) begin
        n_fail++;
        $display("FAIL %s first_addr: got %0d expected %0d", tag, rd_log[i0], H - 1);
      end
      bad_k = -1;
      for (int k = 0; k < int'(H); k++) begin
        if (bad_k < 0 && (rd_log[i0+2*k] != int'(H) - 1 - k || rd_log[i0+2*k+1] != int'(H) + k))
          bad_k = k;
      end
      n_tests++;
      if (bad_k >= 0) begin
        n_fail++;
        $display("FAIL %s addr_order: step %0d got %0d,%0d expected %0d,%0d", tag, bad_k,
                 rd_log[i0+2*bad_k], rd_log[i0+2*bad_k+1], int'(H) - 1 - bad_k, int'(H) + bad_k);
      end
    end
    for (int p = 0; p < int'(NumIo); p++) begin
      n_tests++;
      if (latched[p] !== store[p]) begin
        n_fail++;
        $display("FAIL %s latch_pad%0d: got %h expected %h", tag, p, latched[p], store[p]);
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) step();
    n_tests++;
    if (m_outs !== MRst) begin
      n_fail++;
      $display("FAIL reset_main: got %h expected %h", m_outs, MRst);
    end
    n_tests++;
    if (s_outs !== SRst) begin
      n_fail++;
      $display("FAIL reset_small: got %h expected %h", s_outs, SRst);
    end
    resetb = 1'b1;
    repeat (3) step();
    n_tests++;
    if (m_outs !== MRst) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected %h", m_outs, MRst);
    end
  endtask

  task automatic test_full_load();
    for (int i = 0; i < int'(NumIo); i++) store[i] = Cb'(i * 13);
    full_run("ramp", 1'b0);
    fill_random();
    full_run("random", 1'b0);
  endtask

  task automatic test_modes();
    fill_modes();
    full_run("modes", 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    full_run("b2b_first", 1'b0);
    fill_random();
    full_run("b2b_second", 1'b0);
  endtask

  task automatic test_abort();
    int d0, l0;
    fill_random();
    d0 = done_cnt; l0 = load_cyc;
    m_if.start = 1'b1;
    step();
    m_if.start = 1'b0;
    repeat (499) step();
    m_if.abort = 1'b1;
    step();
    m_if.abort = 1'b0;
    n_tests++;
    if (m_outs !== MRst) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h expected %h", m_outs, MRst);
    end
    repeat (1200) step();
    n_tests++;
    if (done_cnt !== d0 || load_cyc !== l0) begin
      n_fail++;
      $display("FAIL abort_quiet: done %0d load %0d expected 0 0", done_cnt - d0, load_cyc - l0);
    end
    fill_random();
    full_run("abort_restart", 1'b0);
  endtask

  task automatic test_reset_mid();
    int d0, l0;
    fill_random();
    d0 = done_cnt; l0 = load_cyc;
    m_if.start = 1'b1;
    step();
    m_if.start = 1'b0;
    repeat (299) step();
    resetb = 1'b0;
    #1;
    n_tests++;
    if (m_outs !== MRst) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected %h", m_outs, MRst);
    end
    repeat (3) step();
    resetb = 1'b1;
    repeat (20) step();
    n_tests++;
    if (done_cnt !== d0 || load_cyc !== l0 || m_outs !== MRst) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: done %0d load %0d outs %h expected 0 0 %h",
               done_cnt - d0, load_cyc - l0, m_outs, MRst);
    end
    fill_random();
    full_run("after_reset", 1'b0);
  endtask

  task automatic test_ignored_start();
    int d0, b0;
    fill_random();
    full_run("start_while_busy", 1'b1);
    d0 = done_cnt; b0 = busy_cyc;
    m_if.start = 1'b1;
    m_if.abort = 1'b1;
    step();
    m_if.start = 1'b0;
    m_if.abort = 1'b0;
    repeat (20) step();
    n_tests++;
    if (busy_cyc !== b0 || done_cnt !== d0 || m_outs !== MRst) begin
      n_fail++;
      $display("FAIL start_abort_idle: busy %0d done %0d outs %h expected 0 0 %h",
               busy_cyc - b0, done_cnt - d0, m_outs, MRst);
    end
  endtask

  task automatic test_small();
    logic [SH*Cb-1:0] t1, t2;
    logic [Cb-1:0]    lat [SNumIo];
    logic             prev;
    int               busy_n, rising, dn, bad;
    int               addrs[$];
    for (int i = 0; i < int'(SNumIo); i++) s_store[i] = Cb'($urandom);
    for (int i = 0; i < int'(SNumIo); i++) lat[i] = ~s_store[i];
    t1 = '0; t2 = '0; prev = 1'b0; busy_n = 0; rising = 0; dn = 0;
    s_if.start = 1'b1;
    step();
    s_if.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (s_if.busy) busy_n++;
      if (s_if.cfg_rd) addrs.push_back(int'(s_if.cfg_addr));
      if (!s_if.serial_resetn) begin
        t1 = '0;
        t2 = '0;
      end else if (s_if.serial_clock && !prev) begin
        t1 = {t1[SH*Cb-2:0], s_if.serial_data_1};
        t2 = {t2[SH*Cb-2:0], s_if.serial_data_2};
        rising++;
      end
      if (s_if.serial_load) begin
        for (int p = 0; p < int'(SH); p++) begin
          lat[p]    = t1[p*Cb +: Cb];
          lat[SH+p] = t2[(int'(SH)-1-p)*Cb +: Cb];
        end
      end
      prev = s_if.serial_clock;
      if (s_if.done) begin
        dn++;
        break;
      end
      step();
    end
    n_tests++;
    if (dn !== 1 || busy_n !== 60) begin
      n_fail++;
      $display("FAIL small_busy: done %0d busy %0d expected 1 60", dn, busy_n);
    end
    n_tests++;
    if (rising !== int'(SH * Cb)) begin
      n_fail++;
      $display("FAIL small_edges: got %0d expected %0d", rising, SH * Cb);
    end
    bad = (addrs.size() != int'(SNumIo)) ? 1 : 0;
    for (int k = 0; k < int'(SH) && bad == 0; k++) begin
      if (addrs[2*k] != int'(SH) - 1 - k || addrs[2*k+1] != int'(SH) + k) bad = 1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL small_addr_order: got %p expected 1,2,0,3", addrs);
    end
    for (int p = 0; p < int'(SNumIo); p++) begin
      n_tests++;
      if (lat[p] !== s_store[p]) begin
        n_fail++;
        $display("FAIL small_latch_pad%0d: got %h expected %h", p, lat[p], s_store[p]);
      end
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL output_invariants: got %0d violating cycles expected 0", viol);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetb  = 1'b0;
    m_if.start = 1'b0;
    m_if.abort = 1'b0;
    s_if.start = 1'b0;
    s_if.abort = 1'b0;
    for (int i = 0; i < int'(NumIo); i++) store[i] = '0;
    for (int i = 0; i < int'(SNumIo); i++) s_store[i] = '0;
    test_reset();
    test_full_load();
    test_modes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_ignored_start();
    test_small();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
